// File: rtl/taxi_axil_if.sv
// AXI-Lite write and read channel bundle shared by initiators and responders.
// A transfer on any channel happens at a rising clk edge where both valid and ready
// are high. The source keeps valid and its payload stable until that edge, and
// valid never depends combinationally on ready.
interface taxi_axil_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int STRB_W = DATA_W / 8
);
    logic [ADDR_W-1:0] awaddr;
    logic              awvalid;
    logic              awready;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;
    logic [ADDR_W-1:0] araddr;
    logic              arvalid;
    logic              arready;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;

    modport wr_mst (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready,
        input  awready, wready, bresp, bvalid
    );

    modport wr_slv (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready,
        output awready, wready, bresp, bvalid
    );

    modport rd_mst (
        output araddr, arvalid, rready,
        input  arready, rdata, rresp, rvalid
    );

    modport rd_slv (
        input  araddr, arvalid, rready,
        output arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axil_mem_tester.sv
// AXI-Lite memory self-test initiator: LFSR-driven write then read-back pairs,
// with error counting, first-failure capture and a per-handshake watchdog.
module axil_mem_tester #(
    parameter int unsigned NUM_TXN   = 20,
    parameter logic [31:0] SEED      = 32'h0000_0001,
    parameter logic [31:0] ADDR_MASK = 32'h00FF_FFFC,
    parameter int unsigned TIMEOUT   = 1024
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    output logic         busy,
    output logic         done,
    output logic         pass,
    output logic         timeout,
    output logic [15:0]  err_count,
    output logic [31:0]  first_err_addr,
    output logic [15:0]  txn_count,
    output logic [2:0]   dbg_state,
    taxi_axil_if.wr_mst  m_axil_wr,
    taxi_axil_if.rd_mst  m_axil_rd
);
    localparam logic [31:0] SEED_EFF = (SEED == 32'd0) ? 32'd1 : SEED;
    localparam logic [31:0] AMASK    = ADDR_MASK & 32'hFFFF_FFFC;
    localparam logic [16:0] LAST     = 17'(NUM_TXN);
    localparam logic [31:0] WD_LIMIT = 32'(TIMEOUT);
    localparam logic [31:0] POLY     = 32'h8020_0003;

    typedef enum logic [2:0] {
        IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, CHECK, DONE
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] lfsr_q, lfsr_d, lfsr_step;
    logic [31:0] wd_cnt_q, wd_cnt_d;
    logic        awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
    logic        arvalid_q, arvalid_d, rready_q, rready_d;
    logic [31:0] awaddr_q, awaddr_d, wdata_q, wdata_d, araddr_q, araddr_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [15:0] err_q, err_d, txn_q, txn_d;
    logic [31:0] ferr_q, ferr_d;
    logic        tmo_q, tmo_d;
    logic        waiting, err_hit;
    logic [31:0] cur_addr;

    assign lfsr_step = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? POLY : 32'd0);
    assign cur_addr  = lfsr_q & AMASK;
    assign waiting   = (state_q == WR_REQ) || (state_q == WR_RESP) ||
                       (state_q == RD_REQ) || (state_q == RD_RESP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            lfsr_q    <= 32'd0;
            wd_cnt_q  <= 32'd0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            awaddr_q  <= 32'd0;
            wdata_q   <= 32'd0;
            wstrb_q   <= 4'd0;
            araddr_q  <= 32'd0;
            err_q     <= 16'd0;
            txn_q     <= 16'd0;
            ferr_q    <= 32'd0;
            tmo_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            lfsr_q    <= lfsr_d;
            wd_cnt_q  <= wd_cnt_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            araddr_q  <= araddr_d;
            err_q     <= err_d;
            txn_q     <= txn_d;
            ferr_q    <= ferr_d;
            tmo_q     <= tmo_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        lfsr_d    = lfsr_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        bready_d  = bready_q;
        arvalid_d = arvalid_q;
        rready_d  = rready_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        araddr_d  = araddr_q;
        err_d     = err_q;
        txn_d     = txn_q;
        ferr_d    = ferr_q;
        tmo_d     = tmo_q;
        err_hit   = 1'b0;

        // The watchdog wins over any handshake landing in the same cycle.
        if (waiting && (wd_cnt_q == WD_LIMIT)) begin
            awvalid_d = 1'b0;
            wvalid_d  = 1'b0;
            bready_d  = 1'b0;
            arvalid_d = 1'b0;
            rready_d  = 1'b0;
            tmo_d     = 1'b1;
            state_d   = DONE;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        lfsr_d    = SEED_EFF;
                        err_d     = 16'd0;
                        txn_d     = 16'd0;
                        ferr_d    = 32'd0;
                        tmo_d     = 1'b0;
                        awaddr_d  = SEED_EFF & AMASK;
                        wdata_d   = SEED_EFF;
                        wstrb_d   = 4'hF;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = WR_REQ;
                    end
                end
                WR_REQ: begin
                    if (awvalid_q && m_axil_wr.awready) awvalid_d = 1'b0;
                    if (wvalid_q && m_axil_wr.wready)   wvalid_d  = 1'b0;
                    if (!awvalid_d && !wvalid_d) begin
                        bready_d = 1'b1;
                        state_d  = WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (m_axil_wr.bvalid) begin
                        err_hit   = (m_axil_wr.bresp != 2'b00);
                        bready_d  = 1'b0;
                        arvalid_d = 1'b1;
                        araddr_d  = cur_addr;
                        state_d   = RD_REQ;
                    end
                end
                RD_REQ: begin
                    if (m_axil_rd.arready) begin
                        arvalid_d = 1'b0;
                        rready_d  = 1'b1;
                        state_d   = RD_RESP;
                    end
                end
                RD_RESP: begin
                    if (m_axil_rd.rvalid) begin
                        err_hit  = (m_axil_rd.rresp != 2'b00) || (m_axil_rd.rdata != wdata_q);
                        rready_d = 1'b0;
                        state_d  = CHECK;
                    end
                end
                CHECK: begin
                    txn_d  = txn_q + 16'd1;
                    lfsr_d = lfsr_step;
                    if (({1'b0, txn_q} + 17'd1) == LAST) begin
                        state_d = DONE;
                    end else begin
                        awaddr_d  = lfsr_step & AMASK;
                        wdata_d   = lfsr_step;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = WR_REQ;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        if (err_hit) begin
            if (err_q == 16'd0)     ferr_d = cur_addr;
            if (err_q != 16'hFFFF)  err_d  = err_q + 16'd1;
        end

        wd_cnt_d = (waiting && (state_d == state_q)) ? wd_cnt_q + 32'd1 : 32'd0;
    end

    assign busy           = (state_q != IDLE) && (state_q != DONE);
    assign done           = (state_q == DONE);
    assign pass           = done && (err_q == 16'd0) && !tmo_q;
    assign timeout        = tmo_q;
    assign err_count      = err_q;
    assign first_err_addr = ferr_q;
    assign txn_count      = txn_q;
    assign dbg_state      = state_q;

    assign m_axil_wr.awaddr  = awaddr_q;
    assign m_axil_wr.awvalid = awvalid_q;
    assign m_axil_wr.wdata   = wdata_q;
    assign m_axil_wr.wstrb   = wstrb_q;
    assign m_axil_wr.wvalid  = wvalid_q;
    assign m_axil_wr.bready  = bready_q;
    assign m_axil_rd.araddr  = araddr_q;
    assign m_axil_rd.arvalid = arvalid_q;
    assign m_axil_rd.rready  = rready_q;
endmodule

// File: tb/tb_axil_mem_tester.sv
// Bench for axil_mem_tester: memory responder with selectable stall/fault modes,
// LFSR reference sequence and directed runs covering latency, errors, watchdog and reset.
module tb_axil_mem_tester;
  localparam int          N    = 8;
  localparam logic [31:0] SEED = 32'h1234_5678;
  localparam logic [31:0] MASK = 32'h00FF_FFFC;
  localparam int          TMO  = 16;
  localparam int M_ZERO = 0, M_STALL = 1, M_NO_B = 2, M_NO_R = 3;

  logic        clk = 1'b0;
  logic        rst_n, start;
  logic        busy, done, pass, timeout;
  logic [15:0] err_count, txn_count;
  logic [31:0] first_err_addr;
  logic [2:0]  dbg_state;

  taxi_axil_if axil ();

  axil_mem_tester #(.NUM_TXN(N), .SEED(SEED), .ADDR_MASK(MASK), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .busy(busy), .done(done), .pass(pass), .timeout(timeout),
    .err_count(err_count), .first_err_addr(first_err_addr), .txn_count(txn_count),
    .dbg_state(dbg_state),
    .m_axil_wr(axil), .m_axil_rd(axil)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int cyc = 0, t_s = 0;
  int mode = M_ZERO, corrupt_at = 0;
  int aw_cnt = 0, w_cnt = 0, ar_cnt = 0, b_pend = 0, w_gate = 0;
  bit aw_done = 0;
  bit p_aw = 0, p_w = 0, p_ar = 0;
  logic [31:0] p_awaddr, p_wdata, p_araddr;
  logic [31:0] mem [logic [31:0]];
  logic [31:0] awq[$], wq[$], rq[$];
  logic [31:0] exp_q[$], exp_d_q[$];
  logic [31:0] model_addr [N];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Monitor and responder bookkeeping: samples pre-edge values at each rising edge.
  always @(posedge clk) begin
    logic [31:0] e, d;
    cyc++;
    if (!rst_n) begin
      awq.delete(); wq.delete(); rq.delete();
      b_pend = 0; aw_done = 0; p_aw = 0; p_w = 0; p_ar = 0;
    end else begin
      if (p_aw) begin chk("aw_held", 32'(axil.awvalid), 1); chk("awaddr_stable", axil.awaddr, p_awaddr); end
      if (p_w)  begin chk("w_held", 32'(axil.wvalid), 1);   chk("wdata_stable", axil.wdata, p_wdata); end
      if (p_ar) begin chk("ar_held", 32'(axil.arvalid), 1); chk("araddr_stable", axil.araddr, p_araddr); end
      p_aw = axil.awvalid && !axil.awready; p_awaddr = axil.awaddr;
      p_w  = axil.wvalid && !axil.wready;   p_wdata  = axil.wdata;
      p_ar = axil.arvalid && !axil.arready; p_araddr = axil.araddr;
      if (axil.awvalid && axil.awready) begin
        aw_cnt++; aw_done = 1;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        chk("awaddr", axil.awaddr, e);
        awq.push_back(axil.awaddr);
      end
      if (axil.wvalid && axil.wready) begin
        w_cnt++; aw_done = 0;
        e = (exp_d_q.size() > 0) ? exp_d_q.pop_front() : 32'hDEAD_BEEF;
        chk("wdata", axil.wdata, e);
        chk("wstrb", 32'(axil.wstrb), 32'hF);
        wq.push_back(axil.wdata);
      end
      if (axil.bvalid && axil.bready) b_pend--;
      if (awq.size() > 0 && wq.size() > 0) begin
        e = awq.pop_front();
        mem[e] = wq.pop_front();
        b_pend++;
      end
      if (axil.rvalid && axil.rready) void'(rq.pop_front());
      if (axil.arvalid && axil.arready) begin
        ar_cnt++;
        d = mem.exists(axil.araddr) ? mem[axil.araddr] : 32'd0;
        if (ar_cnt == corrupt_at) d = d ^ 32'd1;
        rq.push_back(d);
      end
    end
  end

  // Responder drive, away from the active edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      axil.awready = 0; axil.wready = 0; axil.arready = 0;
      axil.bvalid = 0; axil.bresp = 0; axil.rvalid = 0; axil.rdata = 0; axil.rresp = 0;
      w_gate = 0;
    end else begin
      if (aw_done) w_gate++; else w_gate = 0;
      axil.awready = (mode == M_STALL) ? ($urandom_range(0, 3) != 0) : 1'b1;
      axil.wready  = (mode == M_STALL) ? (w_gate >= 3) : 1'b1;
      axil.arready = (mode == M_STALL) ? ($urandom_range(0, 3) != 0) : 1'b1;
      axil.bresp   = 2'b00;
      axil.bvalid  = (b_pend > 0) && (mode != M_NO_B) &&
                     (mode != M_STALL || axil.bvalid || ($urandom_range(0, 3) != 0));
      axil.rresp   = 2'b00;
      axil.rdata   = (rq.size() > 0) ? rq[0] : 32'd0;
      axil.rvalid  = (rq.size() > 0) && (mode != M_NO_R) &&
                     (mode != M_STALL || axil.rvalid || ($urandom_range(0, 3) != 0));
    end
  end

  task automatic load_model();
    logic [31:0] v;
    v = SEED;
    exp_q.delete(); exp_d_q.delete();
    for (int i = 0; i < N; i++) begin
      model_addr[i] = v & MASK & 32'hFFFF_FFFC;
      exp_q.push_back(model_addr[i]);
      exp_d_q.push_back(v);
      v = (v >> 1) ^ (v[0] ? 32'h8020_0003 : 32'h0);
    end
  endtask

  task automatic do_start();
    t_s = cyc;
    start = 1;
    @(negedge clk);
    start = 0;
  endtask

  task automatic wait_done(input int max, output int lat);
    int i;
    i = 0;
    while (!done && i < max) begin @(negedge clk); i++; end
    chk("done_reached", 32'(done), 1);
    lat = cyc - t_s;
  endtask

  task automatic check_reset_outs(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);       chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_pass"}, 32'(pass), 0);       chk({tag, "_timeout"}, 32'(timeout), 0);
    chk({tag, "_err"}, 32'(err_count), 0);   chk({tag, "_txn"}, 32'(txn_count), 0);
    chk({tag, "_ferr"}, first_err_addr, 0);  chk({tag, "_awvalid"}, 32'(axil.awvalid), 0);
    chk({tag, "_wvalid"}, 32'(axil.wvalid), 0); chk({tag, "_bready"}, 32'(axil.bready), 0);
    chk({tag, "_awaddr"}, axil.awaddr, 0);   chk({tag, "_wdata"}, axil.wdata, 0);
    chk({tag, "_wstrb"}, 32'(axil.wstrb), 0); chk({tag, "_arvalid"}, 32'(axil.arvalid), 0);
    chk({tag, "_rready"}, 32'(axil.rready), 0); chk({tag, "_araddr"}, axil.araddr, 0);
  endtask

  initial begin
    int lat, base_aw, base_w, base_ar, t_b, i;
    rst_n = 0; start = 0;
    repeat (3) @(negedge clk);
    check_reset_outs("reset");
    rst_n = 1;
    @(negedge clk);

    // Run 1: zero-wait responder, first address/data and minimum latency.
    mode = M_ZERO; corrupt_at = 0; load_model();
    base_aw = aw_cnt; base_ar = ar_cnt;
    do_start();
    chk("r1_busy", 32'(busy), 1);
    chk("r1_awvalid", 32'(axil.awvalid), 1);
    chk("r1_wvalid", 32'(axil.wvalid), 1);
    chk("r1_first_awaddr", axil.awaddr, 32'h0034_5678);
    chk("r1_first_wdata", axil.wdata, 32'h1234_5678);
    wait_done(200, lat);
    chk("r1_latency", 32'(lat), 32'(5 * N + 1));
    chk("r1_pass", 32'(pass), 1);
    chk("r1_err", 32'(err_count), 0);
    chk("r1_txn", 32'(txn_count), N);
    chk("r1_timeout", 32'(timeout), 0);
    chk("r1_busy_done", 32'(busy), 0);
    chk("r1_aw_count", 32'(aw_cnt - base_aw), N);
    chk("r1_ar_count", 32'(ar_cnt - base_ar), N);

    // Run 2: awready ahead of wready plus random stalls on every channel.
    @(negedge clk);
    mode = M_STALL; load_model();
    base_aw = aw_cnt; base_w = w_cnt; base_ar = ar_cnt;
    do_start();
    wait_done(3000, lat);
    chk("r2_pass", 32'(pass), 1);
    chk("r2_err", 32'(err_count), 0);
    chk("r2_txn", 32'(txn_count), N);
    chk("r2_aw_count", 32'(aw_cnt - base_aw), N);
    chk("r2_w_count", 32'(w_cnt - base_w), N);
    chk("r2_ar_count", 32'(ar_cnt - base_ar), N);
    chk("r2_exp_left", 32'(exp_q.size()), 0);

    // Run 3: corrupted read-back on the second pair.
    @(negedge clk);
    mode = M_ZERO; load_model();
    corrupt_at = ar_cnt + 2;
    do_start();
    wait_done(200, lat);
    chk("r3_latency", 32'(lat), 32'(5 * N + 1));
    chk("r3_err", 32'(err_count), 1);
    chk("r3_ferr", first_err_addr, model_addr[1]);
    chk("r3_pass", 32'(pass), 0);
    chk("r3_txn", 32'(txn_count), N);
    chk("r3_timeout", 32'(timeout), 0);
    corrupt_at = 0;

    // Run 4: responder never answers the write, watchdog aborts.
    @(negedge clk);
    mode = M_NO_B; load_model();
    do_start();
    i = 0;
    while (!axil.bready && i < 50) begin @(negedge clk); i++; end
    chk("r4_bready_seen", 32'(axil.bready), 1);
    t_b = cyc;
    i = 0;
    while (!done && i < 100) begin @(negedge clk); i++; end
    chk("r4_done", 32'(done), 1);
    chk("r4_wd_latency", 32'(cyc - t_b), 17);
    chk("r4_timeout", 32'(timeout), 1);
    chk("r4_pass", 32'(pass), 0);
    chk("r4_bready_low", 32'(axil.bready), 0);
    chk("r4_txn", 32'(txn_count), 0);

    // Run 5: reset in RD_RESP, then a clean restart from the seed.
    rst_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    mode = M_NO_R; load_model();
    do_start();
    i = 0;
    while (!axil.rready && i < 50) begin @(negedge clk); i++; end
    chk("r5_rready_seen", 32'(axil.rready), 1);
    #1 rst_n = 0;
    #1 check_reset_outs("midrst");
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    mode = M_ZERO; load_model();
    do_start();
    chk("r5_first_awaddr", axil.awaddr, 32'h0034_5678);
    wait_done(200, lat);
    chk("r5_latency", 32'(lat), 32'(5 * N + 1));
    chk("r5_pass", 32'(pass), 1);
    chk("r5_txn", 32'(txn_count), N);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/axil_mem_tester.md
# axil_mem_tester

Synthesizable AXI-Lite initiator that exercises a memory-mapped responder such as `axil_sdram` by issuing a scripted sequence of single-beat write-then-read-back transactions. Addresses and data come from a 32-bit LFSR, and every read-back is compared against the written value. It sits on the master side of the `taxi_axil_if` write and read channels and gives the design an on-chip memory self-test with a pass/fail summary.

## Interface
Parameters:
- `NUM_TXN`, default 20: write/read pairs per run; range 1..65535.
- `SEED`, default 32'h0000_0001: LFSR seed loaded at each start. A value of 0 is replaced by 1.
- `ADDR_MASK`, default 32'h00FF_FFFC: ANDed with the LFSR value to form the address. Bits [1:0] are always forced to 0.
- `TIMEOUT`, default 1024: maximum cycles spent waiting in any single handshake state.

Ports:
- `clk`, in, 1: single clock.
- `rst_n`, in, 1: asynchronous active-low reset.
- `start`, in, 1: starts a run. Sampled only in IDLE or DONE.
- `busy`, out, 1: high from the cycle after start was accepted until DONE.
- `done`, out, 1: level, high in DONE until the next accepted start.
- `pass`, out, 1: valid while done. 1 iff err_count==0 and no timeout occurred.
- `timeout`, out, 1: valid while done. The run aborted on the handshake watchdog.
- `err_count`, out, 16: number of mismatches plus non-OKAY responses. Saturates at 16'hFFFF.
- `first_err_addr`, out, 32: address of the first failing transaction.
- `txn_count`, out, 16: number of completed write/read pairs.
- `m_axil_wr`, taxi_axil_if.wr_mst: drives awaddr, awvalid, wdata, wstrb, wvalid, bready. Observes awready, wready, bresp, bvalid.
- `m_axil_rd`, taxi_axil_if.rd_mst: drives araddr, arvalid, rready. Observes arready, rdata, rresp, rvalid.

## Operation
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, CHECK, DONE.
- IDLE/DONE, start=1:
  - load lfsr=SEED (or 1 if SEED is 0);
  - clear err_count, txn_count, timeout and first_err_addr;
  - go to WR_REQ.
- Per transaction, with v = current lfsr: addr = v & ADDR_MASK & 32'hFFFF_FFFC, data = v, wstrb = 4'hF.
- WR_REQ:
  - assert awvalid and wvalid together.
  - Each valid drops independently after its own handshake (valid & ready at a clock edge).
  - Once both handshakes are done, go to WR_RESP.
- WR_RESP:
  - bready=1.
  - On bvalid: if bresp!=2'b00, record an error. Then go to RD_REQ.
- RD_REQ: arvalid=1 with araddr=addr. On arready, go to RD_RESP.
- RD_RESP:
  - rready=1.
  - On rvalid: capture rdata and rresp. Record an error if rresp!=0 or rdata!=data. Then go to CHECK.
- CHECK:
  - txn_count++.
  - Advance the Galois LFSR: right shift, XOR with 32'h8020_0003 when the LSB is 1.
  - If txn_count+1 == NUM_TXN, go to DONE; else go to WR_REQ.
- Error recording: err_count increments by 1 per erroneous response, saturating. first_err_addr is written only when err_count==0 before the increment.
- Watchdog:
  - the counter resets on every state change;
  - if it reaches TIMEOUT in WR_REQ, WR_RESP, RD_REQ or RD_RESP: drop all valids and readies, set timeout=1, go to DONE.
- A start while busy is ignored.

## Timing
- Reset (rst_n=0, asynchronous): state=IDLE. All of the following are 0:
  - status outputs: busy, done, pass, timeout, err_count, txn_count, first_err_addr;
  - write channel: awvalid, wvalid, bready, awaddr, wdata, wstrb;
  - read channel: arvalid, rready, araddr.
- Reset mid-transaction aborts immediately. No AXI completion is awaited.
- All AXI outputs are registered. awaddr, wdata and araddr are stable for as long as their valid is high.
- awvalid/wvalid rise the cycle after start is sampled.
- Minimum pair latency with zero-wait responder: 5 cycles (WR_REQ, WR_RESP, RD_REQ, RD_RESP, CHECK).
  - A run of NUM_TXN pairs therefore takes ≥ 5·NUM_TXN cycles, plus 1 cycle to DONE.
- Responses arriving in the same cycle as the corresponding ready are accepted that cycle. bvalid or rvalid before a request is accepted is ignored.
- awready and wready in different cycles: each valid stays high until its own handshake. There is no combinational path from ready to valid.
- pass is combinational from done, timeout and err_count, and is only meaningful while done=1.

## Test plan
- SEED=32'h1234_5678, NUM_TXN=1, zero-wait memory model → first awaddr=32'h0034_5678 and wdata=32'h1234_5678; done after 6 cycles; pass=1, txn_count=1.
- NUM_TXN=20 against axil_sdram + MT48LC8M16A2 model → 20 write/read pairs; awaddr sequence matches a reference LFSR; pass=1, err_count=0.
- Responder with awready 3 cycles before wready, plus random valid/ready stalls → no duplicated or dropped handshakes; valids are held stable until accepted; pass=1.
- Memory model corrupting the readback of transaction 2 (bit 0 flipped), SEED=1 → err_count=1, first_err_addr = address of txn 2, pass=0, txn_count=NUM_TXN.
- Responder never asserting bvalid, TIMEOUT=16 → done 17 cycles after entering WR_RESP; timeout=1, pass=0, bready=0 afterwards.
- rst_n pulsed low during RD_RESP, then start again → all outputs return to 0 asynchronously; the new run restarts from SEED with the same first address as the first run.
